// File: rtl/bulk_out_pkt_buf.sv
// bulk_out_pkt_buf: speculative packet buffer that releases only good-CRC packets to AXI-Stream
module bulk_out_pkt_buf #(
  parameter int ABITS   = 11,
  parameter int MAX_PKT = 512
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_tvalid_i,
  input  logic       rx_tlast_i,
  input  logic       rx_crc_ok_i,
  input  logic [7:0] rx_tdata_i,
  output logic       ready_o,
  output logic       drop_o,
  output logic       m_tvalid_o,
  input  logic       m_tready_i,
  output logic       m_tlast_o,
  output logic [7:0] m_tdata_o
);
  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] INC = 1;
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  state_t state;
  logic [8:0] mem [DEPTH];
  logic [ABITS:0] wr_ptr, cm_ptr, rd_ptr, fe_ptr, cm_nxt, rd_nxt, used, cnt_nxt;
  logic [ABITS+1:0] free_nxt;
  logic full, wr_en, commit, xfer, load;
  assign used     = wr_ptr - rd_ptr;
  assign full     = used == (ABITS+1)'(DEPTH);
  assign wr_en    = reset_n & rx_tvalid_i & (state != DROP) & ~full & (~rx_tlast_i | rx_crc_ok_i);
  assign commit   = wr_en & rx_tlast_i;
  assign xfer     = m_tvalid_o & m_tready_i;
  assign load     = (fe_ptr != cm_ptr) & (~m_tvalid_o | m_tready_i);
  assign cm_nxt   = commit ? wr_ptr + INC : cm_ptr;
  assign rd_nxt   = rd_ptr + {{ABITS{1'b0}}, xfer};
  assign cnt_nxt  = cm_nxt - rd_nxt;
  assign free_nxt = (ABITS+2)'(DEPTH) - {1'b0, cnt_nxt};
  // receive FSM: speculative writes, commit on good end-of-packet, rollback on bad CRC or overflow
  always_ff @(posedge clock) begin
    drop_o <= 1'b0;
    if (!reset_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      cm_ptr <= '0;
    end else if (rx_tvalid_i) begin
      if (state == DROP) begin
        if (rx_tlast_i) begin
          drop_o <= 1'b1;
          wr_ptr <= cm_ptr;
          state  <= IDLE;
        end
      end else if (full) begin
        wr_ptr <= cm_ptr;
        drop_o <= rx_tlast_i;
        state  <= rx_tlast_i ? IDLE : DROP;
      end else if (rx_tlast_i && !rx_crc_ok_i) begin
        wr_ptr <= cm_ptr;
        drop_o <= 1'b1;
        state  <= IDLE;
      end else begin
        wr_ptr <= wr_ptr + INC;
        cm_ptr <= cm_nxt;
        state  <= rx_tlast_i ? IDLE : RECV;
      end
    end
  end
  // packet RAM holding {last, data}; left unreset so it maps onto block memory
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[ABITS-1:0]] <= {rx_tlast_i, rx_tdata_i};
  end
  // output side: RAM read lands directly in the held output register; ready tracks next committed fill
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      m_tvalid_o <= 1'b0;
      {m_tlast_o, m_tdata_o} <= '0;
      rd_ptr  <= '0;
      fe_ptr  <= '0;
      ready_o <= 1'b1;
    end else begin
      m_tvalid_o <= load | (m_tvalid_o & ~m_tready_i);
      if (load) begin
        {m_tlast_o, m_tdata_o} <= mem[fe_ptr[ABITS-1:0]];
        fe_ptr <= fe_ptr + INC;
      end
      rd_ptr  <= rd_nxt;
      ready_o <= free_nxt >= (ABITS+2)'(MAX_PKT);
    end
  end
endmodule

// File: tb/tb_bulk_out_pkt_buf.sv
// tb_bulk_out_pkt_buf: directed plus randomized packets checked against a queue-based reference model
module tb_bulk_out_pkt_buf;
  localparam int ABITS   = 4;
  localparam int MAX_PKT = 8;
  localparam int DEPTH   = 1 << ABITS;
  logic clock = 0, reset_n = 0, rx_tvalid_i = 0, rx_tlast_i = 0, rx_crc_ok_i = 0, m_tready_i = 0;
  logic [7:0] rx_tdata_i = 0;
  logic ready_o, drop_o, m_tvalid_o, m_tlast_o;
  logic [7:0] m_tdata_o;
  int checks = 0, errors = 0, cyc = 0, rdy_mode = 1;
  bit in_drop = 0, exp_drop = 0, exp_ready = 1;
  logic [8:0] spec_q[$], cq[$];
  int cq_cyc[$];

  bulk_out_pkt_buf #(.ABITS(ABITS), .MAX_PKT(MAX_PKT)) dut (
    .clock(clock), .reset_n(reset_n),
    .rx_tvalid_i(rx_tvalid_i), .rx_tlast_i(rx_tlast_i), .rx_crc_ok_i(rx_crc_ok_i), .rx_tdata_i(rx_tdata_i),
    .ready_o(ready_o), .drop_o(drop_o),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o), .m_tdata_o(m_tdata_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    check("drop", 9'(drop_o), 9'(exp_drop));
    check("ready", 9'(ready_o), 9'(exp_ready));
    if (cq.size() == 0) check("idle_valid", 9'(m_tvalid_o), 9'd0);
    else begin
      if (cyc - cq_cyc[0] >= 1) check("latency", 9'(m_tvalid_o), 9'd1);
      if (m_tvalid_o) check("byte", {m_tlast_o, m_tdata_o}, cq[0]);
    end
  endtask

  task automatic step(input bit v, input bit l, input bit c, input logic [7:0] d);
    bit full, xfer;
    rx_tvalid_i = v;
    rx_tlast_i  = l;
    rx_crc_ok_i = c;
    rx_tdata_i  = d;
    m_tready_i  = rdy_mode == 0 ? 1'b0 : rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'(cyc % 2) : 1'($urandom_range(1));
    full = (cq.size() + spec_q.size()) == DEPTH;
    xfer = m_tvalid_o & m_tready_i;
    @(posedge clock);
    cyc++;
    if (xfer && cq.size() > 0) begin
      void'(cq.pop_front());
      void'(cq_cyc.pop_front());
    end
    exp_drop = 0;
    if (v) begin
      if (in_drop) begin
        if (l) begin
          exp_drop = 1;
          in_drop = 0;
        end
      end else if (full) begin
        spec_q.delete();
        exp_drop = l;
        in_drop = !l;
      end else if (l && !c) begin
        spec_q.delete();
        exp_drop = 1;
      end else begin
        spec_q.push_back({l, d});
        if (l) begin
          foreach (spec_q[i]) begin
            cq.push_back(spec_q[i]);
            cq_cyc.push_back(cyc);
          end
          spec_q.delete();
        end
      end
    end
    exp_ready = (DEPTH - cq.size()) >= MAX_PKT;
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
  endtask

  task automatic send_pkt(input int len, input bit ok, input bit gaps);
    for (int i = 0; i < len; i++) begin
      step(1, i == len - 1, i == len - 1 ? ok : 1'($urandom_range(1)), 8'($urandom));
      if (gaps && $urandom_range(3) == 0) step(0, 0, 0, 8'h00);
    end
  endtask

  task automatic do_reset();
    reset_n = 0;
    rx_tvalid_i = 0;
    rx_tlast_i = 0;
    m_tready_i = 0;
    @(posedge clock);
    cyc++;
    spec_q.delete();
    cq.delete();
    cq_cyc.delete();
    in_drop = 0;
    exp_drop = 0;
    exp_ready = 1;
    @(negedge clock);
    reset_n = 1;
    check_outputs();
    check("rst_out", {m_tlast_o, m_tdata_o}, 9'd0);
  endtask

  initial begin
    do_reset();
    rdy_mode = 1;
    step(1, 0, 0, 8'h11); step(1, 0, 0, 8'h22); step(1, 0, 0, 8'h33); step(1, 1, 1, 8'h44);
    idle(6);
    step(1, 0, 1, 8'h11); step(1, 0, 1, 8'h22); step(1, 0, 1, 8'h33); step(1, 1, 0, 8'h44);
    step(1, 1, 1, 8'hA5);
    idle(6);
    send_pkt(20, 1, 0);
    idle(4);
    rdy_mode = 0;
    send_pkt(9, 1, 0);
    idle(2);
    rdy_mode = 1;
    idle(1);
    rdy_mode = 0;
    idle(3);
    rdy_mode = 1;
    idle(12);
    rdy_mode = 2;
    send_pkt(3, 1, 0);
    send_pkt(5, 1, 0);
    idle(20);
    rdy_mode = 0;
    send_pkt(4, 1, 0);
    send_pkt(3, 1, 0);
    step(1, 0, 0, 8'h5A);
    step(1, 0, 0, 8'h5B);
    do_reset();
    rdy_mode = 1;
    send_pkt(6, 1, 0);
    idle(10);
    for (int n = 0; n < 400; n++) begin
      rdy_mode = $urandom_range(3);
      send_pkt($urandom_range(1, 20), $urandom_range(9) != 0, 1);
      if ($urandom_range(3) == 0) idle($urandom_range(1, 6));
    end
    rdy_mode = 1;
    idle(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bulk_out_pkt_buf.md
Name: bulk_out_pkt_buf

Overview:
- Packet-commit buffer between the USB receive/protocol layer and the bulk OUT endpoint async FIFO stage.
- Bytes of an incoming DATA packet are written speculatively.
- On the last byte the packet is committed (good CRC) or rolled back (bad CRC / overflow), so only whole, valid packets reach the AXI-Stream output.
- Also generates the ACK/NAK space indication used by the protocol layer at OUT-token time.

Parameters:
ABITS, 11, log2 of buffer depth in bytes (DEPTH = 2^ABITS = 2048)
MAX_PKT, 512, max packet size in bytes; space threshold for ready_o; must be <= DEPTH

Ports:
clock  input  1  USB-side clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
rx_tvalid_i  input  1  received data byte valid (no backpressure; source cannot stall)
rx_tlast_i  input  1  marks last data byte of packet, qualified by rx_tvalid_i
rx_crc_ok_i  input  1  packet CRC16 good; sampled only with rx_tvalid_i & rx_tlast_i
rx_tdata_i  input  8  received data byte
ready_o  output  1  >= MAX_PKT bytes free (committed occupancy); protocol ACKs if 1, NAKs if 0
drop_o  output  1  one-cycle strobe: packet discarded (bad CRC or overflow)
m_tvalid_o  output  1  AXIS output valid
m_tready_i  input  1  AXIS output ready
m_tlast_o  output  1  last byte of committed packet
m_tdata_o  output  8  output byte

Behaviour:
- Clock is clock; reset is synchronous and active-low on reset_n. No other clock or reset.
- Storage: DEPTH x 9 RAM, holding {last, data}. Pointers wr_ptr, cm_ptr, rd_ptr, each ABITS+1 bits with wrap bit.
- Occupancy arithmetic is modulo 2^(ABITS+1):
  - full = (wr_ptr - rd_ptr) == DEPTH
  - committed count = cm_ptr - rd_ptr
- Reset:
  - all pointers 0, FSM IDLE
  - ready_o=1 (registered; requires MAX_PKT <= DEPTH)
  - drop_o=0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0
- FSM states:
  - IDLE: rx_tvalid_i -> write byte, go RECV. If the byte is also tlast, apply the end-of-packet rules in the same cycle and stay IDLE.
  - RECV: each rx_tvalid_i byte written at wr_ptr with last=rx_tlast_i, wr_ptr++.
  - DROP: ignore bytes until rx_tvalid_i & rx_tlast_i, then drop_o=1 for 1 cycle, wr_ptr <= cm_ptr, go IDLE.
- End of packet (rx_tvalid_i & rx_tlast_i, not overflowed):
  - rx_crc_ok_i=1: byte written, cm_ptr <= wr_ptr+1 (commit).
  - rx_crc_ok_i=0: byte not written, wr_ptr <= cm_ptr (rollback), drop_o=1.
  - Either way -> IDLE.
- Overflow: rx_tvalid_i while full (IDLE or RECV):
  - byte discarded, wr_ptr <= cm_ptr
  - if the byte is tlast: drop_o=1, go IDLE; otherwise go DROP
- Zero-length packets never reach this block; the protocol layer handles them.
- ready_o registered: ready_o <= (DEPTH - (cm_ptr - rd_ptr)) >= MAX_PKT. It is not affected by speculative bytes.
- Output side: registered RAM read plus a 1-entry output register (first-word fall-through).
  - A byte committed in cycle C is presented on m_tvalid_o/m_tdata_o no later than cycle C+2 when the output is empty.
  - Reads never pass cm_ptr.
  - Handshake on m_tvalid_o & m_tready_i; rd_ptr advances per transfer.
  - Sustained 1 byte/cycle with m_tready_i held high.
  - Once asserted, m_tvalid_o/m_tdata_o/m_tlast_o are held stable until accepted.
- Simultaneous commit and read in one cycle are both honoured; ready_o reflects both next cycle.
- Reset mid-packet discards all buffered and speculative data; output returns to idle the next cycle.

Test Plan:
- Packet 0x11,0x22,0x33,0x44 with tlast+crc_ok on 0x44, m_tready_i=1 -> output 11,22,33,44 with m_tlast_o only on 44; first byte valid <= 2 cycles after commit; drop_o never asserted.
- Same 4 bytes with crc_ok=0 -> drop_o pulses once, no output, cm_ptr/wr_ptr unchanged. A following good packet 0xA5 is output alone with tlast.
- ABITS=4, MAX_PKT=8: 20-byte good packet -> overflow at byte 17, DROP until tlast, drop_o one pulse, no output.
- ABITS=4, MAX_PKT=8: commit 9 bytes with m_tready_i=0 -> ready_o=0 the cycle after commit; accept 1 byte -> ready_o=1 next cycle.
- Two back-to-back good packets (3 and 5 bytes), m_tready_i toggling every cycle -> all 8 bytes in order, tlast on bytes 3 and 8, data stable while stalled.
- reset_n low for 1 cycle mid-packet after 2 committed packets -> m_tvalid_o=0, ready_o=1; the next packet passes intact.
